// File: rtl/mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// mem_responder_pkg
// Shared types and helpers for the memory responder slice.
//   memory_access_t : request type driven by the CPU (READ or a store width)
//   state_t         : handshake state machine encoding
//   LINE_BYTES      : bytes per cache line (4 doublewords)
//   DW_PER_LINE     : doublewords per line
//   byte_mask()     : 8-bit byte-enable for a store inside one doubleword
// ---------------------------------------------------------------------------
package mem_responder_pkg;

    typedef enum logic [2:0] {
        READ    = 3'd0,
        WRITE_B = 3'd1,
        WRITE_H = 3'd2,
        WRITE_W = 3'd3,
        WRITE_D = 3'd4
    } memory_access_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        ACK     = 2'd2,
        RECOVER = 2'd3
    } state_t;

    localparam int LINE_BYTES  = 32;
    localparam int DW_PER_LINE = 4;

    // Byte enables for a store at byte_offset within a doubleword. Bits shifted
    // past byte 7 fall off, so a misaligned store is truncated rather than
    // spilling into the neighbouring doubleword.
    function automatic logic [7:0] byte_mask(input memory_access_t access,
                                             input logic [2:0]     byte_offset);
        logic [7:0] base_s;
        case (access)
            WRITE_B: base_s = 8'h01;
            WRITE_H: base_s = 8'h03;
            WRITE_W: base_s = 8'h0F;
            WRITE_D: base_s = 8'hFF;
            default: base_s = 8'h00;
        endcase
        return base_s << byte_offset;
    endfunction

endpackage

// File: rtl/mem_responder_ram.sv
// ---------------------------------------------------------------------------
// mem_responder_ram
// DEPTH_LINES x 4 x XLEN single-port synchronous RAM with per-byte write
// enables. One port addressed by line; all four doublewords of the line are
// written/read in parallel. Contents are never reset.
// Ports:
//   clock    : rising-edge clock
//   addr     : line index
//   wr_en    : write strobe, bytes selected by be
//   be       : byte enables across the whole line (byte 0 = dw0 bits 7:0)
//   wr_data  : write data for the whole line
//   rd_en    : read strobe; rd_data updates on the following edge
//   rd_data  : registered read line [3:0][XLEN-1:0]
// ---------------------------------------------------------------------------
module mem_responder_ram
    import mem_responder_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int DEPTH_LINES = 1024,
    parameter int LINE_W      = $clog2(DEPTH_LINES),
    parameter int BE_W        = DW_PER_LINE * XLEN / 8
) (
    input  logic                                 clock,
    input  logic [LINE_W-1:0]                    addr,
    input  logic                                 wr_en,
    input  logic [BE_W-1:0]                      be,
    input  logic [DW_PER_LINE*XLEN-1:0]          wr_data,
    input  logic                                 rd_en,
    output logic [DW_PER_LINE-1:0][XLEN-1:0]     rd_data
);

    logic [DW_PER_LINE*XLEN-1:0] mem_r [DEPTH_LINES];

    // Byte-enabled write and registered line read on the single port.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) begin
                    mem_r[addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_data <= mem_r[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
// Memory-side end of the CPU memory interface. Serves loads, stores and
// 4-doubleword line fills from on-chip RAM after LATENCY wait cycles.
// Port names mirror the CPU side, so directions are inverted here.
// Ports:
//   clock        : rising-edge clock
//   reset        : asynchronous active-high reset
//   mem_cycle    : request valid, held until ack
//   mem_paddr    : byte address of the request
//   mem_access   : READ / WRITE_B / WRITE_H / WRITE_W / WRITE_D
//   mem_data_out : store data, right-aligned
//   mem_data_in  : read line, [0] is the addressed doubleword, wraps in line
//   mem_ack      : one-cycle completion pulse
//   bus_error    : pulses with mem_ack when the address misses the RAM
// ---------------------------------------------------------------------------
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int          XLEN        = 64,
    parameter int          PLEN        = 34,
    parameter int          DEPTH_LINES = 1024,
    parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000,
    parameter int          LATENCY     = 2
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             mem_cycle,
    input  logic [PLEN-1:0]                  mem_paddr,
    input  memory_access_t                   mem_access,
    input  logic [XLEN-1:0]                  mem_data_out,
    output logic [DW_PER_LINE-1:0][XLEN-1:0] mem_data_in,
    output logic                             mem_ack,
    output logic                             bus_error
);

    localparam int              LINE_W  = $clog2(DEPTH_LINES);
    localparam int              CNT_W   = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
    localparam int              BE_W    = DW_PER_LINE * XLEN / 8;
    localparam logic [PLEN-1:0] BASE_P  = BASE_ADDR[PLEN-1:0];
    localparam logic [PLEN:0]   RANGE_P = (PLEN+1)'(DEPTH_LINES * LINE_BYTES);

    state_t                           state_r;
    logic [PLEN-1:0]                  paddr_r;
    memory_access_t                   access_r;
    logic [XLEN-1:0]                  data_r;
    logic [CNT_W-1:0]                 cnt_r;
    logic                             mem_ack_r;
    logic                             bus_error_r;
    logic                             rd_valid_r;

    logic [PLEN-1:0]                  cur_paddr_s;
    memory_access_t                   cur_access_s;
    logic [PLEN-1:0]                  offset_s;
    logic                             in_range_s;
    logic [LINE_W-1:0]                line_s;
    logic [1:0]                       dw_s;
    logic [2:0]                       byte_s;
    logic                             is_read_s;
    logic                             is_write_s;
    logic                             enter_ack_s;
    logic                             wr_en_s;
    logic                             rd_en_s;
    logic [7:0]                       mask_s;
    logic [XLEN-1:0]                  wr_dw_s;
    logic [BE_W-1:0]                  be_s;
    logic [DW_PER_LINE*XLEN-1:0]      wr_line_s;
    logic [DW_PER_LINE-1:0][XLEN-1:0] rd_line_s;

    // Decode the live request while idle (needed for a zero-latency ack),
    // otherwise the latched request.
    always_comb begin
        cur_paddr_s  = paddr_r;
        cur_access_s = access_r;
        if (state_r == IDLE) begin
            cur_paddr_s  = mem_paddr;
            cur_access_s = mem_access;
        end else begin
            cur_paddr_s  = paddr_r;
            cur_access_s = access_r;
        end
        offset_s   = cur_paddr_s - BASE_P;
        // The base comparison rejects addresses whose subtraction wrapped.
        in_range_s = (cur_paddr_s >= BASE_P) && ({1'b0, offset_s} < RANGE_P);
        line_s     = offset_s[5 +: LINE_W];
        dw_s       = offset_s[4:3];
        byte_s     = offset_s[2:0];
    end

    // Classify the access; unknown encodings complete without effect.
    always_comb begin
        is_read_s  = 1'b0;
        is_write_s = 1'b0;
        case (cur_access_s)
            READ:    is_read_s  = 1'b1;
            WRITE_B: is_write_s = 1'b1;
            WRITE_H: is_write_s = 1'b1;
            WRITE_W: is_write_s = 1'b1;
            WRITE_D: is_write_s = 1'b1;
            default: begin
                is_read_s  = 1'b0;
                is_write_s = 1'b0;
            end
        endcase
    end

    // Detect the edge on which the FSM moves into ACK.
    always_comb begin
        enter_ack_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (mem_cycle && (LATENCY == 0)) begin
                    enter_ack_s = 1'b1;
                end else begin
                    enter_ack_s = 1'b0;
                end
            end
            WAIT:    enter_ack_s = (cnt_r <= CNT_W'(1));
            default: enter_ack_s = 1'b0;
        endcase
    end

    // Store datapath: position data and byte enables inside the addressed line.
    always_comb begin
        mask_s    = byte_mask(cur_access_s, byte_s);
        wr_dw_s   = data_r << {byte_s, 3'b000};
        be_s      = BE_W'(mask_s) << {dw_s, 3'b000};
        wr_line_s = {DW_PER_LINE{wr_dw_s}};
        wr_en_s   = (state_r == ACK) && is_write_s && in_range_s;
        rd_en_s   = enter_ack_s && is_read_s && in_range_s;
    end

    mem_responder_ram #(
        .XLEN        (XLEN),
        .DEPTH_LINES (DEPTH_LINES),
        .LINE_W      (LINE_W),
        .BE_W        (BE_W)
    ) u_ram (
        .clock   (clock),
        .addr    (line_s),
        .wr_en   (wr_en_s),
        .be      (be_s),
        .wr_data (wr_line_s),
        .rd_en   (rd_en_s),
        .rd_data (rd_line_s)
    );

    // Handshake FSM with registered ack/error/read-valid flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            paddr_r     <= {PLEN{1'b0}};
            access_r    <= READ;
            data_r      <= {XLEN{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            mem_ack_r   <= 1'b0;
            bus_error_r <= 1'b0;
            rd_valid_r  <= 1'b0;
        end else begin
            // Flags are high only for the single cycle spent in ACK.
            mem_ack_r   <= enter_ack_s;
            bus_error_r <= enter_ack_s && !in_range_s;
            rd_valid_r  <= rd_en_s;
            case (state_r)
                IDLE: begin
                    if (mem_cycle) begin
                        paddr_r  <= mem_paddr;
                        access_r <= mem_access;
                        data_r   <= mem_data_out;
                        cnt_r    <= CNT_W'(LATENCY);
                        state_r  <= enter_ack_s ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    if (enter_ack_s) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ACK;
                    end else begin
                        cnt_r   <= cnt_r - CNT_W'(1);
                    end
                end
                ACK: begin
                    // The store commits on this edge through wr_en_s.
                    state_r <= RECOVER;
                end
                RECOVER: begin
                    // The CPU drops mem_cycle on this edge; do not resample it.
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Rotate the fetched line so element 0 is the addressed doubleword;
    // zero whenever no read data is being returned.
    always_comb begin
        for (int i = 0; i < DW_PER_LINE; i++) begin
            if (rd_valid_r) begin
                mem_data_in[i] = rd_line_s[dw_s + 2'(i)];
            end else begin
                mem_data_in[i] = {XLEN{1'b0}};
            end
        end
    end

    assign mem_ack   = mem_ack_r;
    assign bus_error = bus_error_r;

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
// Directed self-checking bench. dut runs with LATENCY = 2 and the default
// 1024-line RAM; dut0 runs with LATENCY = 0 and a 16-line RAM.
// Latency is counted in rising edges from the edge that samples the newly
// raised mem_cycle: with LATENCY = 2 the ack follows the 3rd edge, i.e. it is
// high in the 4th cycle counting the cycle in which mem_cycle rose; with
// LATENCY = 0 it follows the very first edge.
// ---------------------------------------------------------------------------
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam logic [33:0] BASE    = 34'h0_8000_0000;
    localparam logic [33:0] END_ADR = 34'h0_8000_8000;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 mem_cycle = 1'b0;
    logic                 mem_cycle0 = 1'b0;
    logic [33:0]          mem_paddr = 34'd0;
    memory_access_t       mem_access = READ;
    logic [63:0]          mem_data_out = 64'd0;
    logic [3:0][63:0]     data_in;
    logic [3:0][63:0]     data0;
    logic                 ack, ack0, berr, berr0;

    int vec_cnt    = 0;
    int miscmp_cnt = 0;

    always #5 clock = ~clock;

    mem_responder #(.XLEN(64), .PLEN(34), .DEPTH_LINES(1024),
                    .BASE_ADDR(64'h0000_0000_8000_0000), .LATENCY(2)) dut (
        .clock(clock), .reset(reset), .mem_cycle(mem_cycle),
        .mem_paddr(mem_paddr), .mem_access(mem_access),
        .mem_data_out(mem_data_out), .mem_data_in(data_in),
        .mem_ack(ack), .bus_error(berr));

    mem_responder #(.XLEN(64), .PLEN(34), .DEPTH_LINES(16),
                    .BASE_ADDR(64'h0000_0000_8000_0000), .LATENCY(0)) dut0 (
        .clock(clock), .reset(reset), .mem_cycle(mem_cycle0),
        .mem_paddr(mem_paddr), .mem_access(mem_access),
        .mem_data_out(mem_data_out), .mem_data_in(data0),
        .mem_ack(ack0), .bus_error(berr0));

    task automatic check_vec(input string tag, input logic [255:0] obs,
                             input logic [255:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One full handshake, started at a negedge with the FSM in IDLE; returns
    // at a negedge with the FSM back in IDLE.
    task automatic do_req(input bit sel, input logic [33:0] paddr,
                          input memory_access_t acc, input logic [63:0] data,
                          output int lat, output logic [255:0] line,
                          output logic be);
        int n;
        bit seen;
        mem_paddr = paddr; mem_access = acc; mem_data_out = data;
        if (sel) mem_cycle0 = 1'b1; else mem_cycle = 1'b1;
        n = 0; seen = 1'b0; line = 256'd0; be = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clock);
            n++;
            if (sel ? ack0 : ack) begin
                seen = 1'b1;
                line = sel ? data0 : data_in;
                be   = sel ? berr0 : berr;
            end
        end
        mem_cycle = 1'b0; mem_cycle0 = 1'b0;
        check_vec("ack_seen", {255'd0, seen}, 256'd1);
        lat = n;
        @(negedge clock);
        @(negedge clock);
    endtask

    int          lat, k;
    logic [255:0] line;
    logic        be;
    logic [63:0] a_vals [4];

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        a_vals[0] = 64'hA0; a_vals[1] = 64'hA1;
        a_vals[2] = 64'hA2; a_vals[3] = 64'hA3;

        // Reset state
        @(negedge clock); @(negedge clock);
        check_vec("rst_ack",   {255'd0, ack},  256'd0);
        check_vec("rst_berr",  {255'd0, berr}, 256'd0);
        check_vec("rst_data",  data_in,        256'd0);
        check_vec("rst_ack0",  {255'd0, ack0}, 256'd0);
        reset = 1'b0;
        @(negedge clock);

        // Store then load a doubleword
        do_req(1'b0, BASE + 34'h10, WRITE_D, 64'h1122334455667788, lat, line, be);
        check_vec("wr_lat",  lat, 256'd3);
        check_vec("wr_berr", {255'd0, be}, 256'd0);
        check_vec("wr_data_zero", line, 256'd0);
        do_req(1'b0, BASE + 34'h10, READ, 64'd0, lat, line, be);
        check_vec("rd_lat", lat, 256'd3);
        check_vec("rd_dw0", {192'd0, line[63:0]}, {192'd0, 64'h1122334455667788});

        // Line wrap on read
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, BASE + 34'(8*i), WRITE_D, a_vals[i], lat, line, be);
        end
        do_req(1'b0, BASE + 34'h18, READ, 64'd0, lat, line, be);
        check_vec("rd_wrap", line, {64'hA2, 64'hA1, 64'hA0, 64'hA3});

        // Sub-word stores with truncation at the doubleword boundary
        do_req(1'b0, BASE, WRITE_D, 64'd0, lat, line, be);
        do_req(1'b0, BASE + 34'd5, WRITE_B, 64'hFF, lat, line, be);
        do_req(1'b0, BASE + 34'd7, WRITE_H, 64'hBEEF, lat, line, be);
        do_req(1'b0, BASE, READ, 64'd0, lat, line, be);
        check_vec("rd_bytes", line, {64'hA3, 64'hA2, 64'hA1, 64'hEF00FF0000000000});

        // Out-of-range accesses
        do_req(1'b0, BASE + 34'h7FF8, WRITE_D, 64'h5555, lat, line, be);
        do_req(1'b0, BASE - 34'd8, READ, 64'd0, lat, line, be);
        check_vec("oor_lo_berr", {255'd0, be}, 256'd1);
        check_vec("oor_lo_data", line, 256'd0);
        do_req(1'b0, END_ADR, READ, 64'd0, lat, line, be);
        check_vec("oor_hi_berr", {255'd0, be}, 256'd1);
        check_vec("oor_hi_data", line, 256'd0);
        check_vec("oor_hi_lat", lat, 256'd3);
        do_req(1'b0, END_ADR, WRITE_D, 64'hFFFF_FFFF_FFFF_FFFF, lat, line, be);
        check_vec("oor_wr_berr", {255'd0, be}, 256'd1);
        do_req(1'b0, BASE - 34'd8, WRITE_D, 64'hFFFF_FFFF_FFFF_FFFF, lat, line, be);
        do_req(1'b0, BASE + 34'h7FF8, READ, 64'd0, lat, line, be);
        check_vec("oor_last_kept", {192'd0, line[63:0]}, {192'd0, 64'h5555});
        check_vec("oor_last_berr", {255'd0, be}, 256'd0);
        do_req(1'b0, BASE, READ, 64'd0, lat, line, be);
        check_vec("oor_line0_kept", line, {64'hA3, 64'hA2, 64'hA1, 64'hEF00FF0000000000});

        // Back-to-back with mem_cycle held high
        mem_paddr = BASE + 34'h8; mem_access = READ; mem_cycle = 1'b1;
        k = 0;
        while (!ack && k < 20) begin @(negedge clock); k++; end
        check_vec("b2b_first", {255'd0, ack}, 256'd1);
        check_vec("b2b_first_dw", {192'd0, data_in[0]}, {192'd0, 64'hA1});
        k = 0;
        do begin
            @(negedge clock);
            k++;
            if (k == 1) check_vec("b2b_recover_ack", {255'd0, ack}, 256'd0);
        end while (!ack && k < 20);
        check_vec("b2b_spacing", k, 256'd5);
        mem_cycle = 1'b0;
        @(negedge clock); @(negedge clock);

        // Reset during WAIT abandons a pending store
        do_req(1'b0, BASE + 34'h40, WRITE_D, 64'h1111, lat, line, be);
        mem_paddr = BASE + 34'h40; mem_access = WRITE_D;
        mem_data_out = 64'hDEAD; mem_cycle = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_vec("rst_mid_ack", {255'd0, ack}, 256'd0);
        mem_cycle = 1'b0;
        @(negedge clock);
        check_vec("rst_mid_ack2", {255'd0, ack}, 256'd0);
        reset = 1'b0;
        @(negedge clock);
        check_vec("rst_mid_ack3", {255'd0, ack}, 256'd0);
        do_req(1'b0, BASE + 34'h40, READ, 64'd0, lat, line, be);
        check_vec("rst_mid_lat", lat, 256'd3);
        check_vec("rst_mid_kept", {192'd0, line[63:0]}, {192'd0, 64'h1111});

        // Zero-latency instance
        do_req(1'b1, BASE + 34'h8, WRITE_D, 64'hCAFE, lat, line, be);
        check_vec("l0_wr_lat", lat, 256'd1);
        do_req(1'b1, BASE + 34'h8, READ, 64'd0, lat, line, be);
        check_vec("l0_rd_lat", lat, 256'd1);
        check_vec("l0_rd_dw0", {192'd0, line[63:0]}, {192'd0, 64'hCAFE});
        do_req(1'b1, BASE + 34'h200, READ, 64'd0, lat, line, be);
        check_vec("l0_oor_berr", {255'd0, be}, 256'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
